// File: rtl/fetch_pc_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_pc_sequencer
//
// Program-counter and fetch sequencer placed directly in front of the
// instruction memory. A start command selects a demo program whose base
// address is prog_sel*BASE_STEP. The sequencer then fetches one word per
// cycle until it sees the OUT instruction (opcode 4'b0001). A watchdog limits
// a program to MAX_LEN words. After the last fetch it waits DRAIN_CYC cycles
// for the downstream pipeline to empty, then pulses done for one cycle.
//
// Ports
//   clk            in   1     system clock, rising edge
//   reset          in   1     asynchronous, active-high reset
//   start          in   1     one-cycle start request (accepted only in IDLE)
//   prog_sel       in   4     program number, sampled together with start
//   M_instruction  in   16    instruction word at PCAdd_pc (combinational)
//   stall          in   1     fetch stall (present only with STALL_EN)
//   PCAdd_pc       out  PC_W  registered fetch address
//   inst_valid     out  1     M_instruction is a live fetch this cycle
//   busy           out  1     high while fetching or draining
//   done           out  1     one-cycle completion pulse
//   err            out  1     sticky error, cleared by the next accepted start
//
// Configuration macro
//   STALL_EN : adds the stall input. While stall is high in FETCH the PC
//              holds, inst_valid is low, the watchdog count is frozen and OUT
//              detection is suppressed. Undefined by default.
// ---------------------------------------------------------------------------
module fetch_pc_sequencer #(
    parameter int PC_W      = 16,
    parameter int BASE_STEP = 100,
    parameter int NUM_PROG  = 9,
    parameter int DRAIN_CYC = 4,
    parameter int MAX_LEN   = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      prog_sel,
    input  logic [15:0]     M_instruction,
`ifdef STALL_EN
    input  logic            stall,
`endif
    output logic [PC_W-1:0] PCAdd_pc,
    output logic            inst_valid,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam int DRN_W = $clog2(DRAIN_CYC + 1);

    // Word index of the final fetch the watchdog allows (counter is 0-based).
    localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(MAX_LEN - 1);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_CYC - 1);
    localparam logic [3:0]       MAX_SEL    = 4'(NUM_PROG);
    localparam logic [PC_W-1:0]  STEP       = PC_W'(BASE_STEP);
    localparam logic [3:0]       OP_OUT     = 4'b0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  wordCnt_q, wordCnt_d;
    logic [DRN_W-1:0]  drainCnt_q, drainCnt_d;

    logic              fetchStall;
    logic              selOk;
    logic              isOut;
    logic [PC_W-1:0]   startPc;
    logic              unusedInstBits;

`ifdef STALL_EN
    assign fetchStall = stall;
`else
    assign fetchStall = 1'b0;
`endif

    // Only the opcode field matters to the sequencer; the operand bits are
    // folded into a deliberately unused signal.
    assign unusedInstBits = ^M_instruction[11:0];

    assign selOk   = (prog_sel != 4'd0) && (prog_sel <= MAX_SEL);
    assign isOut   = (M_instruction[15:12] == OP_OUT);
    // Product is truncated to PC_W bits on purpose.
    assign startPc = PC_W'(prog_sel) * STEP;

    // State, PC, error flag and both counters share one register process.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            err_q      <= 1'b0;
            wordCnt_q  <= '0;
            drainCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            err_q      <= err_d;
            wordCnt_q  <= wordCnt_d;
            drainCnt_q <= drainCnt_d;
        end
    end

    // Next-state logic. OUT detection is checked before the watchdog so an
    // OUT on the very last allowed word finishes cleanly with no error.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        err_d      = err_q;
        wordCnt_d  = wordCnt_q;
        drainCnt_d = drainCnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (selOk) begin
                        pc_d       = startPc;
                        err_d      = 1'b0;
                        wordCnt_d  = '0;
                        drainCnt_d = '0;
                        state_d    = FETCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            FETCH: begin
                if (!fetchStall) begin
                    wordCnt_d = wordCnt_q + 1'b1;
                    if (isOut) begin
                        drainCnt_d = '0;
                        state_d    = DRAIN;
                    end else if (wordCnt_q == LAST_WORD) begin
                        err_d      = 1'b1;
                        drainCnt_d = '0;
                        state_d    = DRAIN;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end

            DRAIN: begin
                if (drainCnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drainCnt_d = drainCnt_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode the registered state so reset clears them immediately.
    always_comb begin
        PCAdd_pc   = pc_q;
        err        = err_q;
        inst_valid = (state_q == FETCH) && !fetchStall;
        busy       = (state_q == FETCH) || (state_q == DRAIN);
        done       = (state_q == DONE);
    end

endmodule
